// File: rtl/simplebus_pkg.sv
// Shared definitions for the simple bus: arbiter states, master indices,
// idle select code and index/one-hot conversion.
package simplebus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int         NUM_MASTERS = 3;
    localparam logic [1:0] M0          = 2'd0;
    localparam logic [1:0] M1          = 2'd1;
    localparam logic [1:0] M2          = 2'd2;
    localparam logic [1:0] SEL_IDLE    = 2'b11;

    // Maps a mux select code to the matching grant bit; idle code gives no grant.
    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_MASTERS-1:0] oh;
        case (idx)
            M0:      oh = 3'b001;
            M1:      oh = 3'b010;
            M2:      oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three masters: first set bit of mask
// searching last+1, last+2, last (mod 3).
module rr_pick3
    import simplebus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] mask,
    input  logic [1:0]             last,
    output logic [1:0]             idx,
    output logic                   valid
);

    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // Search order rotated so the most recent owner is tried last.
    always_comb begin
        first_s  = M0;
        second_s = M1;
        third_s  = M2;
        case (last)
            M0: begin
                first_s  = M1;
                second_s = M2;
                third_s  = M0;
            end
            M1: begin
                first_s  = M2;
                second_s = M0;
                third_s  = M1;
            end
            default: begin
                first_s  = M0;
                second_s = M1;
                third_s  = M2;
            end
        endcase
    end

    // Take the first candidate present in the mask.
    always_comb begin
        idx   = SEL_IDLE;
        valid = 1'b0;
        if (mask[first_s]) begin
            idx   = first_s;
            valid = 1'b1;
        end else if (mask[second_s]) begin
            idx   = second_s;
            valid = 1'b1;
        end else if (mask[third_s]) begin
            idx   = third_s;
            valid = 1'b1;
        end else begin
            idx   = SEL_IDLE;
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/bus_arbiter3.sv
// Round-robin arbiter for three bus masters with a hold limit that forces
// re-arbitration under contention; drives the mux select and one-hot grant.
module bus_arbiter3
    import simplebus_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [1:0]             sel,
    output logic                   busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t                 state_r;
    logic [1:0]             sel_r;
    logic [NUM_MASTERS-1:0] grant_r;
    logic                   busy_r;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [1:0]             last_r;

    logic [NUM_MASTERS-1:0] owner_bit_s;
    logic                   owner_req_s;
    logic                   others_s;
    logic                   force_s;
    logic [NUM_MASTERS-1:0] mask_s;
    logic [1:0]             pick_idx_s;
    logic                   pick_valid_s;

    // Owner status and the candidate mask: the owner is excluded only on a forced release.
    always_comb begin
        owner_bit_s = 3'b000;
        owner_req_s = 1'b0;
        others_s    = 1'b0;
        force_s     = 1'b0;
        mask_s      = req;
        if (state_r == OWN) begin
            owner_bit_s = idx_to_onehot(sel_r);
            owner_req_s = |(req & owner_bit_s);
            others_s    = |(req & ~owner_bit_s);
            force_s     = owner_req_s && others_s && (hold_cnt_r == HOLD_LAST);
        end else begin
            owner_bit_s = 3'b000;
        end
        if (force_s) begin
            mask_s = req & ~owner_bit_s;
        end else begin
            mask_s = req;
        end
    end

    rr_pick3 u_pick (
        .mask  (mask_s),
        .last  (last_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Arbitration FSM with hold counter, last-owner pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            sel_r      <= SEL_IDLE;
            grant_r    <= 3'b000;
            busy_r     <= 1'b0;
            hold_cnt_r <= '0;
            last_r     <= M2;
        end else begin
            case (state_r)
                IDLE: begin
                    hold_cnt_r <= '0;
                    if (pick_valid_s) begin
                        state_r <= OWN;
                        sel_r   <= pick_idx_s;
                        grant_r <= idx_to_onehot(pick_idx_s);
                        busy_r  <= 1'b1;
                        last_r  <= pick_idx_s;
                    end else begin
                        state_r <= IDLE;
                        sel_r   <= SEL_IDLE;
                        grant_r <= 3'b000;
                        busy_r  <= 1'b0;
                    end
                end
                OWN: begin
                    if (!owner_req_s || force_s) begin
                        hold_cnt_r <= '0;
                        if (pick_valid_s) begin
                            state_r <= OWN;
                            sel_r   <= pick_idx_s;
                            grant_r <= idx_to_onehot(pick_idx_s);
                            busy_r  <= 1'b1;
                            last_r  <= pick_idx_s;
                        end else begin
                            state_r <= IDLE;
                            sel_r   <= SEL_IDLE;
                            grant_r <= 3'b000;
                            busy_r  <= 1'b0;
                        end
                    end else if (hold_cnt_r != HOLD_LAST) begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end else begin
                        // Sole requester at the limit keeps the bus with the counter saturated.
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    sel_r      <= SEL_IDLE;
                    grant_r    <= 3'b000;
                    busy_r     <= 1'b0;
                    hold_cnt_r <= '0;
                end
            endcase
        end
    end

    assign grant = grant_r;
    assign sel   = sel_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_bus_arbiter3.sv
// Scoreboard bench for bus_arbiter3 built with a hold limit of 4.
module tb_bus_arbiter3;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;

    int passed;
    int total;

    typedef struct {
        logic [2:0] grant;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    bus_arbiter3 #(.MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_sel(input logic [2:0] g);
        case (g)
            3'b001:  return 2'b00;
            3'b010:  return 2'b01;
            3'b100:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic apply_reset();
        req = 3'b000;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [2:0] req_tab [5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        logic [2:0] exp_tab [5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 3'($urandom_range(0, 7));
            sb_q.push_back('{grant: 3'b000, name: "reset_held"});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if (grant !== e.grant) $display("FAIL %s grant got %b want %b", e.name, grant, e.grant);
            else passed++;
            total++;
            if (sel !== exp_sel(e.grant)) $display("FAIL %s sel got %b want %b", e.name, sel, exp_sel(e.grant));
            else passed++;
            total++;
            if (busy !== (|e.grant)) $display("FAIL %s busy got %b want %b", e.name, busy, |e.grant);
            else passed++;
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = req_tab[i];
            sb_q.push_back('{grant: exp_tab[i], name: "reset_release"});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if (grant !== e.grant) $display("FAIL %s[%0d] grant got %b want %b", e.name, i, grant, e.grant);
            else passed++;
            total++;
            if (sel !== exp_sel(e.grant)) $display("FAIL %s[%0d] sel got %b want %b", e.name, i, sel, exp_sel(e.grant));
            else passed++;
            total++;
            if (busy !== (|e.grant)) $display("FAIL %s[%0d] busy got %b want %b", e.name, i, busy, |e.grant);
            else passed++;
        end
    endtask

    task automatic test_single();
        exp_t e;
        logic [2:0] req_tab [3] = '{3'b010, 3'b010, 3'b000};
        logic [2:0] exp_tab [3] = '{3'b010, 3'b010, 3'b000};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            req = req_tab[i];
            sb_q.push_back('{grant: exp_tab[i], name: "single"});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if (grant !== e.grant) $display("FAIL %s[%0d] grant got %b want %b", e.name, i, grant, e.grant);
            else passed++;
            total++;
            if (sel !== exp_sel(e.grant)) $display("FAIL %s[%0d] sel got %b want %b", e.name, i, sel, exp_sel(e.grant));
            else passed++;
            total++;
            if (busy !== (|e.grant)) $display("FAIL %s[%0d] busy got %b want %b", e.name, i, busy, |e.grant);
            else passed++;
        end
    endtask

    task automatic test_rr_order();
        exp_t e;
        logic [2:0] req_tab [5] = '{3'b111, 3'b110, 3'b100, 3'b101, 3'b001};
        logic [2:0] exp_tab [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            req = req_tab[i];
            sb_q.push_back('{grant: exp_tab[i], name: "rr_order"});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if (grant !== e.grant) $display("FAIL %s[%0d] grant got %b want %b", e.name, i, grant, e.grant);
            else passed++;
            total++;
            if (sel !== exp_sel(e.grant)) $display("FAIL %s[%0d] sel got %b want %b", e.name, i, sel, exp_sel(e.grant));
            else passed++;
            total++;
            if (busy !== (|e.grant)) $display("FAIL %s[%0d] busy got %b want %b", e.name, i, busy, |e.grant);
            else passed++;
        end
    endtask

    task automatic test_hold_limit();
        exp_t e;
        // Master 0 owns for exactly 4 cycles, then master 2 with no gap, then back to 0.
        logic [2:0] req_tab [7] = '{3'b001, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b001};
        logic [2:0] exp_tab [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b001};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            req = req_tab[i];
            sb_q.push_back('{grant: exp_tab[i], name: "hold_limit"});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if (grant !== e.grant) $display("FAIL %s[%0d] grant got %b want %b", e.name, i, grant, e.grant);
            else passed++;
            total++;
            if (sel !== exp_sel(e.grant)) $display("FAIL %s[%0d] sel got %b want %b", e.name, i, sel, exp_sel(e.grant));
            else passed++;
            total++;
            if (busy !== (|e.grant)) $display("FAIL %s[%0d] busy got %b want %b", e.name, i, busy, |e.grant);
            else passed++;
        end
    endtask

    task automatic test_sole_owner();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            req = 3'b010;
            sb_q.push_back('{grant: 3'b010, name: "sole_owner"});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if (grant !== e.grant) $display("FAIL %s[%0d] grant got %b want %b", e.name, i, grant, e.grant);
            else passed++;
            total++;
            if (sel !== exp_sel(e.grant)) $display("FAIL %s[%0d] sel got %b want %b", e.name, i, sel, exp_sel(e.grant));
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [2:0] req_tab [3] = '{3'b111, 3'b110, 3'b100};
        logic [2:0] exp_tab [3] = '{3'b001, 3'b010, 3'b100};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            req = req_tab[i];
            sb_q.push_back('{grant: exp_tab[i], name: "async_pre"});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if (grant !== e.grant) $display("FAIL %s[%0d] grant got %b want %b", e.name, i, grant, e.grant);
            else passed++;
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (grant !== 3'b000) $display("FAIL async_rst grant got %b want 000", grant);
        else passed++;
        total++;
        if (sel !== 2'b11) $display("FAIL async_rst sel got %b want 11", sel);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL async_rst busy got %b want 0", busy);
        else passed++;
        #1;
        rst = 1'b0;
        req = 3'b111;
        sb_q.push_back('{grant: 3'b001, name: "async_post"});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        total++;
        if (grant !== e.grant) $display("FAIL %s grant got %b want %b", e.name, grant, e.grant);
        else passed++;
        total++;
        if (sel !== exp_sel(e.grant)) $display("FAIL %s sel got %b want %b", e.name, sel, exp_sel(e.grant));
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        req    = 3'b000;
        test_reset();
        test_single();
        test_rr_order();
        test_hold_limit();
        test_sole_owner();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
